fetch_unit: RTL and testbench

Instruction fetch front end for the 16-bit core; the read-side initiator of the instruction memory. Drives the 10-bit instruction address, captures the 16-bit word returned combinationally by the instruction memory, and buffers fetched words in a small prefetch queue. Delivers words to decode over a valid/ready handshake. Supports branch redirect with queue flush, and a halt request with acknowledge.

---
 rtl/fetch_if.sv | 45 ++++
 rtl/fetch_unit.sv | 109 ++++++++++
 tb/tb_fetch_unit.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// Fetch unit bus bundle: instruction-memory read port, decode handshake,
// and the redirect/halt control inputs from the core.
interface fetch_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_data;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              halt;
    logic              halt_ack;

    // Fetch unit side.
    modport master (
        output im_addr,
        input  im_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect,
        input  redirect_pc,
        input  halt,
        output halt_ack
    );

    // Memory / decode / core side.
    modport slave (
        input  im_addr,
        output im_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect,
        output redirect_pc,
        output halt,
        input  halt_ack
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the PC onto the instruction memory,
// captures the combinationally returned word into a small prefetch queue and
// hands words to decode over valid/ready. Redirect flushes the queue and
// reloads the PC; halt stops fetching and acknowledges once the queue drains.
module fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter int          DATA_W   = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int          DEPTH    = 2
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] RESET_PC_V = ADDR_W'(RESET_PC);

    localparam logic [0:0] S_RUN  = 1'b0;
    localparam logic [0:0] S_HALT = 1'b1;

    logic [ADDR_W-1:0] pc;
    logic [0:0]        state;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];

    logic empty;
    logic full;
    logic pop;
    logic push;

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // A pop at full frees the slot the incoming word lands in, so a stalled
    // queue restarts without a bubble.
    assign pop  = !empty && bus.instr_ready;
    assign push = (state == S_RUN) && !bus.halt && !bus.redirect && (!full || pop);

    // Memory address comes straight from the PC register.
    assign bus.im_addr = pc;

    assign bus.instr_valid = !empty;
    assign bus.instr       = empty ? '0 : q_data[rd_ptr];
    assign bus.instr_pc    = empty ? '0 : q_pc[rd_ptr];
    assign bus.halt_ack    = (state == S_HALT) && empty;

    // PC: redirect wins, otherwise advance (wrapping) on every fetched word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC_V;
        end else if (bus.redirect) begin
            pc <= bus.redirect_pc;
        end else if (push) begin
            pc <= pc + ADDR_W'(1);
        end
    end

    // Run/halt state; a redirect leaves the state untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RUN;
        end else if (!bus.redirect) begin
            if (state == S_RUN && bus.halt) begin
                state <= S_HALT;
            end else if (state == S_HALT && !bus.halt) begin
                state <= S_RUN;
            end
        end
    end

    // Queue occupancy and pointers; redirect flushes everything, including a
    // word decode takes in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (bus.redirect) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Queue storage holds data only; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[wr_ptr] <= bus.im_data;
            q_pc[wr_ptr]   <= pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a ROM model returns addr+0x100, and every
// fetched word is queued as expected output then compared when decode takes it.
module tb_fetch_unit;
    localparam int          ADDR_W   = 10;
    localparam int          DATA_W   = 16;
    localparam int          DEPTH    = 2;
    localparam int unsigned RESET_PC = 0;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) + 16'h0100;
    endfunction

    assign bus.im_data = rom(bus.im_addr);

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    ent_t              exp_q [$];
    logic [ADDR_W-1:0] m_pc;
    bit                m_halt;

    task automatic model_reset();
        exp_q.delete();
        m_pc   = ADDR_W'(RESET_PC);
        m_halt = 1'b0;
    endtask

    // Check outputs mid-cycle, then advance the expected state across the edge.
    task automatic step();
        int   sz;
        bit   pop;
        bit   push;
        ent_t e;
        @(negedge clk);
        sz = exp_q.size();
        check("instr_valid", 32'(bus.instr_valid), 32'(sz > 0));
        if (sz > 0) begin
            check("instr", 32'(bus.instr), 32'(exp_q[0].data));
            check("instr_pc", 32'(bus.instr_pc), 32'(exp_q[0].pc));
        end else begin
            check("instr_empty", 32'(bus.instr), 32'd0);
            check("instr_pc_empty", 32'(bus.instr_pc), 32'd0);
        end
        check("im_addr", 32'(bus.im_addr), 32'(m_pc));
        check("halt_ack", 32'(bus.halt_ack), 32'(m_halt && sz == 0));
        pop  = (sz > 0) && bus.instr_ready;
        push = !m_halt && !bus.halt && !bus.redirect && (sz < DEPTH || pop);
        if (pop) void'(exp_q.pop_front());
        if (bus.redirect) begin
            exp_q.delete();
            m_pc = bus.redirect_pc;
        end else if (push) begin
            e.pc   = m_pc;
            e.data = rom(m_pc);
            exp_q.push_back(e);
            m_pc = m_pc + ADDR_W'(1);
        end
        if (!bus.redirect) begin
            if (!m_halt && bus.halt) m_halt = 1'b1;
            else if (m_halt && !bus.halt) m_halt = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_im_addr"}, 32'(bus.im_addr), 32'(RESET_PC));
        check({tag, "_instr"}, 32'(bus.instr), 32'd0);
        check({tag, "_instr_pc"}, 32'(bus.instr_pc), 32'd0);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
        check({tag, "_halt_ack"}, 32'(bus.halt_ack), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [ADDR_W-1:0] wrap_exp [4];
        logic [ADDR_W-1:0] frozen;

        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.halt        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b1;

        // Streaming, then a decode stall and gap-free restart.
        bus.instr_ready = 1'b1;
        repeat (3) step();
        bus.instr_ready = 1'b0;
        repeat (5) step();
        check("stall_im_addr", 32'(bus.im_addr), 32'(2 + DEPTH));
        bus.instr_ready = 1'b1;
        repeat (6) step();

        // Redirect to 0x3F0 after six cycles of streaming.
        do_reset();
        bus.instr_ready = 1'b1;
        repeat (6) step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h3F0;
        step();
        bus.redirect = 1'b0;
        check("redir_valid_low", 32'(bus.instr_valid), 32'd0);
        step();
        check("redir_target_pc", 32'(bus.instr_pc), 32'h3F0);
        check("redir_target_valid", 32'(bus.instr_valid), 32'd1);
        repeat (3) step();

        // Redirect near the top of memory: the PC wraps to zero.
        wrap_exp[0] = 10'h3FE;
        wrap_exp[1] = 10'h3FF;
        wrap_exp[2] = 10'h000;
        wrap_exp[3] = 10'h001;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h3FE;
        step();
        bus.redirect = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            check("wrap_pc", 32'(bus.instr_pc), 32'(wrap_exp[i]));
            step();
        end

        // Halt with a full queue: drain, acknowledge, freeze, then resume.
        bus.instr_ready = 1'b0;
        repeat (3) step();
        check("halt_pre_full", 32'(bus.instr_valid), 32'd1);
        bus.halt        = 1'b1;
        bus.instr_ready = 1'b1;
        step();
        frozen = bus.im_addr;
        repeat (DEPTH + 2) step();
        check("halt_ack_set", 32'(bus.halt_ack), 32'd1);
        check("halt_frozen", 32'(bus.im_addr), 32'(frozen));
        bus.halt = 1'b0;
        step();
        step();
        check("resume_pc", 32'(bus.instr_pc), 32'(frozen));
        check("resume_valid", 32'(bus.instr_valid), 32'd1);
        repeat (3) step();

        // Asynchronous reset mid-stream with a full queue and redirect pending.
        bus.instr_ready = 1'b0;
        repeat (3) step();
        bus.redirect    = 1'b1;
        bus.redirect_pc = 10'h155;
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("midrst");
        model_reset();
        bus.redirect = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        step();
        check("post_rst_pc", 32'(bus.instr_pc), 32'(RESET_PC));
        check("post_rst_valid", 32'(bus.instr_valid), 32'd1);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
